// File: rtl/qracc_pkg.sv
// Shared definitions for the QR-ACC SRAM access sequencer.
//   - qracc_sram_state_t : sequencer state encoding. The write-verify states
//     VPRE/VWL/VSENSE exist only when QRACC_SRAM_WRVERIFY_EN is defined.
//   - default geometry and strobe timing constants.
//   - qracc_max3         : helper used to size the phase counter.
package qracc_pkg;

  localparam int QRACC_NUM_ROWS     = 128;
  localparam int QRACC_NUM_COLS     = 32;
  localparam int QRACC_PCH_CYCLES   = 1;
  localparam int QRACC_WL_CYCLES    = 2;
  localparam int QRACC_SENSE_CYCLES = 1;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WLON,
    SENSE,
    CAP
`ifdef QRACC_SRAM_WRVERIFY_EN
    , VPRE,
    VWL,
    VSENSE
`endif
  } qracc_sram_state_t;

  function automatic int qracc_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/qracc_onehot_dec.sv
// Row address to one-hot word-line decoder with enable.
// Ports:
//   en     : when 0 the output is all zeros
//   addr   : row address
//   onehot : numRows-wide one-hot row select (bit addr set when en=1)
module qracc_onehot_dec #(
  parameter int numRows = 128
) (
  input  logic                       en,
  input  logic [$clog2(numRows)-1:0] addr,
  output logic [numRows-1:0]         onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/qracc_sram_ctrl.sv
// SRAM access sequencer between the sram_itf slave request port and the SRAM
// control fields of the analog QR-ACC macro. One read or write is accepted at
// a time and sequenced as precharge -> word line (+ write drive) -> sense amp
// -> capture. New requests are held off while the macro is in a MAC phase.
//
// Ports:
//   clk, nrst        : clock, asynchronous active-low reset
//   mac_busy_i       : macro computing; gates acceptance only
//   rq_valid_i/rq_ready_o, rq_wr_i, addr_i, wr_data_i : request handshake
//   rd_valid_o, rd_data_o : one-cycle read-return pulse and held read data
//   WL, PCH, WR_DATA, WRITE, CSEL, SAEN : macro strobes (all registered)
//   SA_OUT           : sense-amp outputs from the macro
//   wr_verify_err_o  : only with QRACC_SRAM_WRVERIFY_EN; one-cycle pulse when
//                      the read-back after a write differs from the write data
//
// Optional build macro: QRACC_SRAM_WRVERIFY_EN (write read-back verify).
module qracc_sram_ctrl
  import qracc_pkg::*;
#(
  parameter int numRows     = QRACC_NUM_ROWS,
  parameter int numCols     = QRACC_NUM_COLS,
  parameter int PchCycles   = QRACC_PCH_CYCLES,
  parameter int WlCycles    = QRACC_WL_CYCLES,
  parameter int SenseCycles = QRACC_SENSE_CYCLES
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       mac_busy_i,
  input  logic                       rq_wr_i,
  input  logic                       rq_valid_i,
  output logic                       rq_ready_o,
  input  logic [$clog2(numRows)-1:0] addr_i,
  input  logic [numCols-1:0]         wr_data_i,
  output logic                       rd_valid_o,
  output logic [numCols-1:0]         rd_data_o,
`ifdef QRACC_SRAM_WRVERIFY_EN
  output logic                       wr_verify_err_o,
`endif
  output logic [numRows-1:0]         WL,
  output logic                       PCH,
  output logic [numCols-1:0]         WR_DATA,
  output logic                       WRITE,
  output logic [numCols-1:0]         CSEL,
  output logic                       SAEN,
  input  logic [numCols-1:0]         SA_OUT
);

  localparam int AddrW  = $clog2(numRows);
  localparam int MaxCyc = qracc_max3(PchCycles, WlCycles, SenseCycles);
  localparam int CntW   = $clog2(MaxCyc + 1);

  localparam logic [CntW-1:0] PchReload   = CntW'(PchCycles - 1);
  localparam logic [CntW-1:0] WlReload    = CntW'(WlCycles - 1);
  localparam logic [CntW-1:0] SenseReload = CntW'(SenseCycles - 1);

  qracc_sram_state_t  state, state_n;
  logic [CntW-1:0]    cnt, cnt_n;
  logic [AddrW-1:0]   addr_q;
  logic               wr_q;
  logic [numCols-1:0] data_q;

  logic               accept;
  logic               last;
  logic               pch_n, wl_on_n, write_n, saen_n;
  logic [numRows-1:0] wl_dec;

  assign rq_ready_o = (state == IDLE) && !mac_busy_i;
  assign accept     = rq_valid_i && rq_ready_o;
  assign last       = (cnt == '0);

  // Next state and phase counter. The counter is loaded with (duration-1)
  // on every state entry and the phase ends when it reaches zero.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = PRE;
          cnt_n   = PchReload;
        end
      end
      PRE: begin
        if (last) begin
          state_n = WLON;
          cnt_n   = WlReload;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      WLON: begin
        if (last) begin
          if (wr_q) begin
`ifdef QRACC_SRAM_WRVERIFY_EN
            state_n = VPRE;
            cnt_n   = PchReload;
`else
            state_n = IDLE;
            cnt_n   = '0;
`endif
          end else begin
            state_n = SENSE;
            cnt_n   = SenseReload;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      SENSE: begin
        if (last) begin
          state_n = CAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      CAP: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
`ifdef QRACC_SRAM_WRVERIFY_EN
      VPRE: begin
        if (last) begin
          state_n = VWL;
          cnt_n   = WlReload;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      VWL: begin
        if (last) begin
          state_n = VSENSE;
          cnt_n   = SenseReload;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      VSENSE: begin
        // CAP doubles as the one-cycle verify result slot; rd_valid_o is
        // only raised on the SENSE->CAP path.
        if (last) begin
          state_n = CAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Strobe levels for the state being entered; registering them against
  // state_n makes each strobe line up exactly with its state.
  always_comb begin
    pch_n   = (state_n == PRE);
    wl_on_n = (state_n == WLON) || (state_n == SENSE);
    saen_n  = (state_n == SENSE);
`ifdef QRACC_SRAM_WRVERIFY_EN
    pch_n   = pch_n   || (state_n == VPRE);
    wl_on_n = wl_on_n || (state_n == VWL) || (state_n == VSENSE);
    saen_n  = saen_n  || (state_n == VSENSE);
`endif
    write_n = (state_n == WLON) && wr_q;
  end

  qracc_onehot_dec #(
    .numRows (numRows)
  ) u_wl_dec (
    .en     (wl_on_n),
    .addr   (addr_q),
    .onehot (wl_dec)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      PCH        <= 1'b0;
      WL         <= '0;
      CSEL       <= '0;
      WRITE      <= 1'b0;
      WR_DATA    <= '0;
      SAEN       <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
`ifdef QRACC_SRAM_WRVERIFY_EN
      wr_verify_err_o <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        addr_q <= addr_i;
        wr_q   <= rq_wr_i;
        data_q <= wr_data_i;
      end
      PCH        <= pch_n;
      WL         <= wl_dec;
      CSEL       <= {numCols{wl_on_n}};
      WRITE      <= write_n;
      WR_DATA    <= write_n ? data_q : '0;
      SAEN       <= saen_n;
      rd_valid_o <= (state == SENSE) && (state_n == CAP);
      if ((state == SENSE) && (state_n == CAP)) rd_data_o <= SA_OUT;
`ifdef QRACC_SRAM_WRVERIFY_EN
      wr_verify_err_o <= (state == VSENSE) && (state_n == CAP) && (SA_OUT != data_q);
`endif
    end
  end

endmodule

// File: tb/tb_qracc_sram_ctrl.sv
// Self-checking bench for qracc_sram_ctrl. Expected strobe traces are built
// from the phase durations (precharge, word line, sense, capture) as cycle
// ranges counted from the accept edge; SA_OUT comes from a bench-side memory.
// Covers QRACC_SRAM_WRVERIFY_EN when that macro is defined for the build.
module tb_qracc_sram_ctrl;
  localparam int NR = 128;
  localparam int NC = 32;
  localparam int AW = $clog2(NR);
  localparam int P  = 1;
  localparam int W  = 2;
  localparam int S  = 1;
  localparam int VW = 6 + NR + 3 * NC;
`ifdef QRACC_SRAM_WRVERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          mac_busy_i = 1'b0;
  logic          rq_wr_i = 1'b0;
  logic          rq_valid_i = 1'b0;
  logic          rq_ready_o;
  logic [AW-1:0] addr_i = '0;
  logic [NC-1:0] wr_data_i = '0;
  logic          rd_valid_o;
  logic [NC-1:0] rd_data_o;
  logic [NR-1:0] WL;
  logic          PCH;
  logic [NC-1:0] WR_DATA;
  logic          WRITE;
  logic [NC-1:0] CSEL;
  logic          SAEN;
  logic [NC-1:0] sa_out = '0;
  logic          wr_verify_err;

  int            checks = 0;
  int            errors = 0;
  logic [NC-1:0] mem [NR];
  logic [NC-1:0] exp_rd;

  always #5 clk = ~clk;

  qracc_sram_ctrl #(
    .numRows     (NR),
    .numCols     (NC),
    .PchCycles   (P),
    .WlCycles    (W),
    .SenseCycles (S)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .mac_busy_i (mac_busy_i),
    .rq_wr_i    (rq_wr_i),
    .rq_valid_i (rq_valid_i),
    .rq_ready_o (rq_ready_o),
    .addr_i     (addr_i),
    .wr_data_i  (wr_data_i),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
`ifdef QRACC_SRAM_WRVERIFY_EN
    .wr_verify_err_o (wr_verify_err),
`endif
    .WL         (WL),
    .PCH        (PCH),
    .WR_DATA    (WR_DATA),
    .WRITE      (WRITE),
    .CSEL       (CSEL),
    .SAEN       (SAEN),
    .SA_OUT     (sa_out)
  );

`ifndef QRACC_SRAM_WRVERIFY_EN
  initial wr_verify_err = 1'b0;
`endif

  function automatic bit in_rng(input int k, input int lo, input int hi);
    return (k >= lo) && (k <= hi);
  endfunction

  // One access: optional request drive, accept edge, then a cycle-by-cycle
  // comparison until rq_ready_o returns. hold keeps rq_valid_i high with
  // garbage fields mid-access and restores the request in the ready cycle.
  task automatic do_access(input bit wr, input logic [AW-1:0] a,
                           input logic [NC-1:0] d, input bit hold,
                           input bit pre, input int busy_k,
                           input logic [NC-1:0] flip);
    int fin, v0;
    bit busy_on, pch, wl, wre, sae, rdv, err, rdy;
    logic [NR-1:0] onehot, wl_exp;
    logic [NC-1:0] csel_exp, wd_exp;
    logic [VW-1:0] got, exp;
    busy_on = 1'b0;
    onehot  = '0;
    onehot[a] = 1'b1;
    v0 = P + W;
    if (!pre) begin
      @(negedge clk);
      rq_wr_i = wr; addr_i = a; wr_data_i = d; rq_valid_i = 1'b1; mac_busy_i = 1'b0;
      #1;
      checks++;
      if (rq_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL accept_ready: got %b expected 1", rq_ready_o);
      end
    end
    sa_out = wr ? (d ^ flip) : mem[a];
    @(posedge clk);
    #1;
    if (!hold) rq_valid_i = 1'b0;
    if (wr) mem[a] = d;
    fin = wr ? (VER ? 2*P + 2*W + S + 2 : P + W + 1) : P + W + S + 2;
    for (int k = 1; k <= fin; k++) begin
      @(negedge clk);
      pch = in_rng(k, 1, P) || (VER && wr && in_rng(k, v0 + 1, v0 + P));
      wl  = wr ? (in_rng(k, P + 1, P + W) || (VER && in_rng(k, v0 + P + 1, v0 + P + W + S)))
               : in_rng(k, P + 1, P + W + S);
      wre = wr && in_rng(k, P + 1, P + W);
      sae = wr ? (VER && in_rng(k, v0 + P + W + 1, v0 + P + W + S))
               : in_rng(k, P + W + 1, P + W + S);
      rdv = !wr && (k == P + W + S + 1);
      err = VER && wr && (flip != '0) && (k == v0 + P + W + S + 1);
      rdy = (k == fin) && !busy_on;
      if (rdv) exp_rd = mem[a];
      wl_exp   = wl ? onehot : '0;
      csel_exp = wl ? '1 : '0;
      wd_exp   = wre ? d : '0;
      exp = {pch, wre, sae, rdv, err, rdy, wl_exp, csel_exp, wd_exp, exp_rd};
      got = {PCH, WRITE, SAEN, rd_valid_o, wr_verify_err, rq_ready_o, WL, CSEL, WR_DATA, rd_data_o};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL trace wr=%0d addr=%0d cycle %0d: got %h expected %h", wr, a, k, got, exp);
      end
      checks++;
      if ((int'(PCH) + int'(SAEN) + int'(WRITE) > 1) || (PCH && (WL != '0))) begin
        errors++;
        $display("FAIL exclusive cycle %0d: got PCH=%b SAEN=%b WRITE=%b WL!=0=%b expected at most one strobe, no WL under PCH",
                 k, PCH, SAEN, WRITE, WL != '0);
      end
      if (k == busy_k) begin
        mac_busy_i = 1'b1;
        busy_on = 1'b1;
      end
      if (k < fin) begin
        rq_wr_i = 1'($urandom); addr_i = AW'($urandom); wr_data_i = $urandom;
      end else if (hold) begin
        rq_wr_i = wr; addr_i = a; wr_data_i = d;
      end
    end
    if (busy_on) begin
      mac_busy_i = 1'b0;
      #1;
      checks++;
      if (rq_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL busy_release: got %b expected 1", rq_ready_o);
      end
    end
  endtask

  task automatic test_reset();
    logic [VW-1:0] got;
    for (int i = 0; i < NR; i++) mem[i] = $urandom;
    exp_rd = '0;
    #12;
    got = {PCH, WRITE, SAEN, rd_valid_o, wr_verify_err, rq_ready_o, WL, CSEL, WR_DATA, rd_data_o};
    checks++;
    if (got !== {6'b000001, {(VW-6){1'b0}}}) begin
      errors++;
      $display("FAIL reset_values: got %h expected only ready set", got);
    end
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if (rq_ready_o !== 1'b1 || PCH !== 1'b0 || WL !== '0) begin
      errors++;
      $display("FAIL post_reset: got ready=%b PCH=%b WL=%h expected 1 0 0", rq_ready_o, PCH, WL);
    end
  endtask

  task automatic test_write();
    do_access(1'b1, AW'(5), 32'hDEADBEEF, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic test_read();
    do_access(1'b0, AW'(5), '0, 1'b0, 1'b0, 0, '0);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rd_data_o !== 32'hDEADBEEF || rd_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL read_hold: got data=%h valid=%b expected deadbeef 0", rd_data_o, rd_valid_o);
      end
    end
  endtask

  task automatic test_busy();
    @(negedge clk);
    mac_busy_i = 1'b1; rq_valid_i = 1'b1; rq_wr_i = 1'b0; addr_i = AW'(7);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({rq_ready_o, PCH, WRITE, SAEN, WL != '0} !== 5'b0) begin
        errors++;
        $display("FAIL busy_block: got ready=%b PCH=%b WRITE=%b SAEN=%b expected all 0",
                 rq_ready_o, PCH, WRITE, SAEN);
      end
    end
    do_access(1'b0, AW'(7), '0, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic test_busy_mid();
    do_access(1'b0, AW'(5), '0, 1'b0, 1'b0, 2, '0);
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] oh;
    oh = '0;
    oh[9] = 1'b1;
    @(negedge clk);
    rq_wr_i = 1'b1; addr_i = AW'(9); wr_data_i = $urandom; rq_valid_i = 1'b1;
    @(posedge clk);
    #1 rq_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (WL !== oh || WRITE !== 1'b1) begin
      errors++;
      $display("FAIL mid_write: got WL=%h WRITE=%b expected %h 1", WL, WRITE, oh);
    end
    #1 nrst = 1'b0;
    #1;
    checks++;
    if ({PCH, WRITE, SAEN, rd_valid_o} !== 4'b0 || WL !== '0 || CSEL !== '0 ||
        WR_DATA !== '0 || rd_data_o !== '0) begin
      errors++;
      $display("FAIL async_reset: got WL=%h WRITE=%b CSEL=%h rd_data=%h expected all 0",
               WL, WRITE, CSEL, rd_data_o);
    end
    exp_rd = '0;
    @(negedge clk);
    nrst = 1'b1;
    do_access(1'b0, AW'(0), '0, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [NC-1:0] d;
    a = AW'($urandom);
    d = $urandom;
    do_access(1'b1, a, d, 1'b1, 1'b0, 0, '0);
    do_access(1'b1, a, d, 1'b0, 1'b1, 0, '0);
    do_access(1'b0, a, '0, 1'b1, 1'b0, 0, '0);
    do_access(1'b0, a, '0, 1'b0, 1'b1, 0, '0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      do_access(1'($urandom), AW'($urandom), $urandom, 1'b0, 1'b0, 0, '0);
    end
  endtask

`ifdef QRACC_SRAM_WRVERIFY_EN
  task automatic test_verify();
    do_access(1'b1, AW'(3), 32'h0000_0001, 1'b0, 1'b0, 0, 32'h0000_0001);
    do_access(1'b1, AW'(3), 32'h0000_0001, 1'b0, 1'b0, 0, '0);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_busy();
    test_busy_mid();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef QRACC_SRAM_WRVERIFY_EN
    test_verify();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qracc_sram_ctrl.md
Name: qracc_sram_ctrl

Overview:
- Digital sequencer that sits between the SRAM request interface (slave side of sram_itf) and the SRAM control fields of the analog macro.
- Accepts one read or write request at a time.
- Sequences precharge, word-line, write and sense-amp strobes, and returns captured SA_OUT as rd_data_o.
- Blocks new requests while the macro is in a compute (MAC) phase.

Parameters:
- numRows, 128, SRAM rows; one-hot WL width.
- numCols, 32, SRAM columns; data, CSEL and SA_OUT width.
- PchCycles, 1, precharge duration in cycles (>=1).
- WlCycles, 2, word-line / write-drive duration in cycles (>=1).
- SenseCycles, 1, SAEN duration in cycles, reads only (>=1).

Ports:
- clk  input  1  system clock.
- nrst  input  1  asynchronous active-low reset.
- mac_busy_i  input  1  macro in compute phase; no SRAM access allowed.
- rq_wr_i  input  1  1 = write, 0 = read.
- rq_valid_i  input  1  request valid.
- rq_ready_o  output  1  request accepted when rq_valid_i && rq_ready_o.
- addr_i  input  $clog2(numRows)  row address.
- wr_data_i  input  numCols  write data.
- rd_valid_o  output  1  one-cycle pulse; rd_data_o valid.
- rd_data_o  output  numCols  captured read data.
- WL  output  numRows  one-hot word line.
- PCH  output  1  bit-line precharge, active high.
- WR_DATA  output  numCols  write drivers.
- WRITE  output  1  write enable.
- CSEL  output  numCols  column select.
- SAEN  output  1  sense-amp enable.
- SA_OUT  input  numCols  sense-amp outputs.

Behaviour:
- Clock and reset: one clock (clk); reset nrst is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, counters 0, rd_data_o 0.
- rq_ready_o = (state==IDLE) && !mac_busy_i, combinational.
  - After reset deassertion, rq_ready_o is 1 if mac_busy_i is 0.
- Accept: on a clk edge with rq_valid_i && rq_ready_o, register addr_i, rq_wr_i and wr_data_i, then go to PRE.
- FSM: IDLE -> PRE -> WLON -> (read: SENSE -> CAP | write: IDLE).
- PRE: PCH=1 for PchCycles cycles. WL=0, WRITE=0, SAEN=0.
- WLON: lasts WlCycles cycles.
  - WL = 1<<addr_q.
  - CSEL = all ones.
  - Write: WRITE=1 and WR_DATA=data_q; then go to IDLE.
  - Read: WRITE=0 and WR_DATA=0.
- SENSE (read only): lasts SenseCycles cycles. WL and CSEL held, SAEN=1. On the last SENSE cycle, rd_data_o <= SA_OUT; go to CAP.
- CAP: rd_valid_o=1 for exactly one cycle, all strobes 0, then IDLE.
- rd_data_o holds until the next read capture. Writes never change rd_data_o.
- Latency with defaults, counted from the accept edge (cycle 0):
  - Read: PRE cycle 1, WLON cycles 2-3, SENSE cycle 4, rd_valid_o in cycle 5, rq_ready_o back in cycle 6.
  - Write: PRE cycle 1, WLON cycles 2-3, rq_ready_o back in cycle 4.
- Strobe exclusivity: PCH, SAEN and WRITE are never high in the same cycle. WL is 0 whenever PCH=1.
- mac_busy_i asserting mid-access does not abort the access. It only gates the next acceptance.
- Inputs are ignored outside IDLE; rq_valid_i may stay high and is accepted once ready returns.
- Reset mid-access: all strobes drop asynchronously to 0, FSM returns to IDLE, and any pending rd_valid_o is lost.
- Counter width is $clog2(max(PchCycles, WlCycles, SenseCycles)+1). The counter reloads on every state entry.

Optional Feature:
- Macro: QRACC_SRAM_WRVERIFY_EN.
- Enabled:
  - Adds output wr_verify_err_o (1 bit).
  - After every write, the FSM performs PRE -> WLON(read) -> SENSE internally at the same address; no rd_valid_o pulse is generated.
  - If SA_OUT != data_q, wr_verify_err_o pulses for one cycle, then IDLE.
  - Write occupancy grows by PchCycles+WlCycles+SenseCycles+1 cycles.
- Disabled: no port, no verify states; behaviour as above.

Decomposition:
- qracc_pkg holds:
  - the state enum typedef qracc_sram_state_t (IDLE, PRE, WLON, SENSE, CAP, plus VPRE, VWL, VSENSE under the macro);
  - default timing constants.
- to_sram_t/from_sram_t remain the flattened-port equivalents.
- One natural sub-module: qracc_onehot_dec (addr -> numRows one-hot with enable), reused by the compute-path row drivers.

Test Plan:
- Reset then write addr=5, data=32'hDEADBEEF:
  - PCH high cycle 1;
  - WL==1<<5, WRITE=1, WR_DATA=DEADBEEF in cycles 2-3;
  - rq_ready_o=1 in cycle 4.
- Read addr=5 with SA_OUT model returning DEADBEEF: rd_valid_o pulses in cycle 5 only, with rd_data_o=DEADBEEF; rd_data_o is unchanged afterwards.
- mac_busy_i=1 while rq_valid_i=1: rq_ready_o=0, no strobe activity. Dropping busy gives acceptance on the next edge.
- mac_busy_i rises during WLON of a read: the access completes normally and rd_valid_o still pulses in cycle 5.
- nrst low during WLON of a write: WL=0 and WRITE=0 immediately without waiting for a clock. After release, a read of addr=0 works normally.
- QRACC_SRAM_WRVERIFY_EN with SA_OUT model flipping bit 0:
  - write 32'h0000_0001 -> wr_verify_err_o pulses once, no rd_valid_o;
  - same write with a correct model -> no error pulse.
